// File: rtl/hsstl_rst4mcrsw_pkg.sv
// Shared constants for the RX status filter: default debounce counts,
// synchronizer reset values and the debounce counter width helper.
package hsstl_rst4mcrsw_pkg;

    localparam int SYNC_STAGES_DEF      = 2;
    localparam int LOS_ASSERT_CNT_DEF   = 4;
    localparam int LOS_DEASSERT_CNT_DEF = 64;
    localparam int CDR_LOCK_CNT_DEF     = 128;
    localparam int CDR_DROP_CNT         = 1;
    localparam int WA_ASSERT_CNT_DEF    = 8;
    localparam int WA_DROP_CNT_DEF      = 4;
    localparam int EVT_CNT_WIDTH_DEF    = 8;

    // Loss is assumed present until proven otherwise; lock/align assumed absent.
    localparam logic SYNC_RST_LOS = 1'b1;
    localparam logic SYNC_RST_CDR = 1'b0;
    localparam logic SYNC_RST_WA  = 1'b0;

    function automatic int cnt_width(input int max_n);
        return $clog2(max_n) + 1;
    endfunction

endpackage

// File: rtl/hsstl_rst4mcrsw_debounce_v1_0.sv
// Asymmetric debounce: dout flips after N consecutive differing samples,
// N chosen by the direction of travel; hold forces hold_val and clears the count.
module hsstl_rst4mcrsw_debounce_v1_0
    import hsstl_rst4mcrsw_pkg::*;
#(
    parameter int   ASSERT_CNT   = 4,
    parameter int   DEASSERT_CNT = 64,
    parameter logic RST_VAL      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    input  logic hold_val,
    input  logic din,
    output logic dout
);

    localparam int MAX_N = (ASSERT_CNT > DEASSERT_CNT) ? ASSERT_CNT : DEASSERT_CNT;
    localparam int CW    = cnt_width(MAX_N);

    logic          f_q, f_d;
    logic [CW-1:0] c_q, c_d;
    logic [CW-1:0] lim;

    always_comb begin
        f_d = f_q;
        c_d = c_q;
        lim = f_q ? CW'(DEASSERT_CNT - 1) : CW'(ASSERT_CNT - 1);
        if (hold) begin
            f_d = hold_val;
            c_d = '0;
        end else if (din == f_q) begin
            c_d = '0;
        end else if (c_q == lim) begin
            f_d = din;
            c_d = '0;
        end else begin
            c_d = c_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q <= RST_VAL;
            c_q <= '0;
        end else begin
            f_q <= f_d;
            c_q <= c_d;
        end
    end

    assign dout = f_q;

endmodule

// File: rtl/hsstl_rst4mcrsw_rx_status_filter_v1_0.sv
// Synchronizes and debounces raw HSST lane status for the RX init FSM, gates
// lock/align on loss, and counts loss assertions. Raw edge to filter state: SYNC_STAGES+N clocks.
module hsstl_rst4mcrsw_rx_status_filter_v1_0
    import hsstl_rst4mcrsw_pkg::*;
#(
    parameter int SYNC_STAGES      = SYNC_STAGES_DEF,
    parameter int LOS_ASSERT_CNT   = LOS_ASSERT_CNT_DEF,
    parameter int LOS_DEASSERT_CNT = LOS_DEASSERT_CNT_DEF,
    parameter int CDR_LOCK_CNT     = CDR_LOCK_CNT_DEF,
    parameter int WA_ASSERT_CNT    = WA_ASSERT_CNT_DEF,
    parameter int WA_DROP_CNT      = WA_DROP_CNT_DEF,
    parameter int EVT_CNT_WIDTH    = EVT_CNT_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     P_RX_PMA_RSTN,
    input  logic                     raw_los,
    input  logic                     raw_cdr_lock,
    input  logic                     raw_word_align,
    input  logic                     evt_cnt_clr,
    output logic                     loss_signal,
    output logic                     cdr_align,
    output logic                     word_align,
    output logic [EVT_CNT_WIDTH-1:0] los_evt_cnt
);

    logic [SYNC_STAGES-1:0] los_sync_q, cdr_sync_q, wa_sync_q;
    logic                   los_f, cdr_f, wa_f;
    logic                   hold;
    logic                   los_prev_q;
    logic [EVT_CNT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            los_sync_q <= {SYNC_STAGES{SYNC_RST_LOS}};
            cdr_sync_q <= {SYNC_STAGES{SYNC_RST_CDR}};
            wa_sync_q  <= {SYNC_STAGES{SYNC_RST_WA}};
        end else begin
            los_sync_q <= {los_sync_q[SYNC_STAGES-2:0], raw_los};
            cdr_sync_q <= {cdr_sync_q[SYNC_STAGES-2:0], raw_cdr_lock};
            wa_sync_q  <= {wa_sync_q[SYNC_STAGES-2:0],  raw_word_align};
        end
    end

    assign hold = ~P_RX_PMA_RSTN;

    hsstl_rst4mcrsw_debounce_v1_0 #(
        .ASSERT_CNT  (LOS_ASSERT_CNT),
        .DEASSERT_CNT(LOS_DEASSERT_CNT),
        .RST_VAL     (1'b1)
    ) u_los (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .hold_val(1'b1),
        .din     (los_sync_q[SYNC_STAGES-1]),
        .dout    (los_f)
    );

    hsstl_rst4mcrsw_debounce_v1_0 #(
        .ASSERT_CNT  (CDR_LOCK_CNT),
        .DEASSERT_CNT(CDR_DROP_CNT),
        .RST_VAL     (1'b0)
    ) u_cdr (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .hold_val(1'b0),
        .din     (cdr_sync_q[SYNC_STAGES-1]),
        .dout    (cdr_f)
    );

    hsstl_rst4mcrsw_debounce_v1_0 #(
        .ASSERT_CNT  (WA_ASSERT_CNT),
        .DEASSERT_CNT(WA_DROP_CNT),
        .RST_VAL     (1'b0)
    ) u_wa (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .hold_val(1'b0),
        .din     (wa_sync_q[SYNC_STAGES-1]),
        .dout    (wa_f)
    );

    // A rise of los_f (debounced or forced by PMA hold) is seen one clock later.
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (evt_cnt_clr) begin
            evt_cnt_d = '0;
        end else if (los_f && !los_prev_q && (evt_cnt_q != {EVT_CNT_WIDTH{1'b1}})) begin
            evt_cnt_d = evt_cnt_q + EVT_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            los_prev_q <= 1'b1;
            evt_cnt_q  <= '0;
        end else begin
            los_prev_q <= los_f;
            evt_cnt_q  <= evt_cnt_d;
        end
    end

    assign loss_signal = los_f;
    assign cdr_align   = cdr_f & ~los_f;
    assign word_align  = wa_f & cdr_f & ~los_f;
    assign los_evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_hsstl_rst4mcrsw_rx_status_filter_v1_0.sv
// Directed bench for the RX status filter with a sample-window reference model.
module tb_hsstl_rst4mcrsw_rx_status_filter_v1_0;

    localparam int SS = 2;
    localparam int NUP[3] = '{4, 128, 8};
    localparam int NDN[3] = '{64, 1, 4};
    localparam bit RSTV[3] = '{1'b1, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pma_rstn = 1'b1;
    logic       raw_los = 1'b0;
    logic       raw_cdr = 1'b0;
    logic       raw_wa = 1'b0;
    logic       clr = 1'b0;
    logic       loss_signal, cdr_align, word_align;
    logic [7:0] los_evt_cnt;

    int n_chk = 0;
    int n_fail = 0;
    bit run = 1'b0;

    hsstl_rst4mcrsw_rx_status_filter_v1_0 dut (
        .clk           (clk),
        .rst           (rst),
        .P_RX_PMA_RSTN (pma_rstn),
        .raw_los       (raw_los),
        .raw_cdr_lock  (raw_cdr),
        .raw_word_align(raw_wa),
        .evt_cnt_clr   (clr),
        .loss_signal   (loss_signal),
        .cdr_align     (cdr_align),
        .word_align    (word_align),
        .los_evt_cnt   (los_evt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: raw history per edge; a filter flips when the last N
    // samples since its last flip/hold all disagree with its current value.
    int   kk;
    int   evt[3];
    logic mf[3];
    logic rawh[3][256];
    logic rose_q;
    int   mcnt;
    logic rawv[3];
    int   nn;
    bit   okw;
    logic rose_now;

    function logic samp(input int ch, input int e);
        if (e - SS < 1) return RSTV[ch];
        return rawh[ch][(e - SS) % 256];
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                kk = 0;
                rose_q = 1'b0;
                mcnt = 0;
                for (int c = 0; c < 3; c++) begin
                    evt[c] = 0;
                    mf[c] = RSTV[c];
                end
            end else begin
                kk++;
                rawv[0] = raw_los;
                rawv[1] = raw_cdr;
                rawv[2] = raw_wa;
                if (clr) mcnt = 0;
                else if (rose_q && mcnt != 255) mcnt++;
                rose_now = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    rawh[c][kk % 256] = rawv[c];
                    if (!pma_rstn) begin
                        if (c == 0 && !mf[0]) rose_now = 1'b1;
                        mf[c] = RSTV[c];
                        evt[c] = kk;
                    end else begin
                        nn = mf[c] ? NDN[c] : NUP[c];
                        okw = (kk - evt[c]) >= nn;
                        for (int j = 0; j < nn; j++)
                            if (samp(c, kk - j) == mf[c]) okw = 1'b0;
                        if (okw) begin
                            if (c == 0 && !mf[0]) rose_now = 1'b1;
                            mf[c] = ~mf[c];
                            evt[c] = kk;
                        end
                    end
                end
                rose_q = rose_now;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (run) begin
                chk("model_loss", loss_signal, mf[0]);
                chk("model_cdr",  cdr_align,  mf[1] & ~mf[0]);
                chk("model_wa",   word_align, mf[2] & mf[1] & ~mf[0]);
                chk("model_cnt",  los_evt_cnt, mcnt);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic los_pulse(input int hi, input int lo);
        raw_los = 1'b1;
        cyc(hi);
        raw_los = 1'b0;
        cyc(lo);
    endtask

    initial begin
        #1 rst = 1'b1;
        cyc(3);
        run = 1'b1;
        chk("rst_loss", loss_signal, 1);
        chk("rst_cdr", cdr_align, 0);
        chk("rst_cnt", los_evt_cnt, 0);
        rst = 1'b0;

        // loss clears 2+64 edges after release
        cyc(65);
        chk("los_clr_65", loss_signal, 1);
        cyc(1);
        chk("los_clr_66", loss_signal, 0);
        chk("los_clr_cdr", cdr_align, 0);
        chk("los_clr_wa", word_align, 0);
        chk("los_clr_cnt", los_evt_cnt, 0);

        raw_cdr = 1'b1;
        cyc(129);
        chk("cdr_129", cdr_align, 0);
        cyc(1);
        chk("cdr_130", cdr_align, 1);

        raw_wa = 1'b1;
        cyc(7);
        raw_wa = 1'b0;
        cyc(12);
        chk("wa_glitch7", word_align, 0);
        raw_wa = 1'b1;
        cyc(9);
        chk("wa_edge9", word_align, 0);
        cyc(1);
        chk("wa_edge10", word_align, 1);
        raw_wa = 1'b0;
        cyc(3);
        raw_wa = 1'b1;
        cyc(10);
        chk("wa_lowpulse3", word_align, 1);

        raw_cdr = 1'b0;
        cyc(1);
        raw_cdr = 1'b1;
        chk("cdr_drop_e1", cdr_align, 1);
        cyc(1);
        chk("cdr_drop_e2", cdr_align, 1);
        cyc(1);
        chk("cdr_drop_e3", cdr_align, 0);
        chk("cdr_drop_wa", word_align, 0);
        cyc(140);
        chk("relock_cdr", cdr_align, 1);
        chk("relock_wa", word_align, 1);

        los_pulse(3, 10);
        chk("los_pulse3", loss_signal, 0);
        raw_los = 1'b1;
        cyc(4);
        raw_los = 1'b0;
        cyc(1);
        chk("los_pulse4_e5", loss_signal, 0);
        cyc(1);
        chk("los_pulse4_e6", loss_signal, 1);
        chk("los_pulse4_cdr", cdr_align, 0);
        chk("los_pulse4_wa", word_align, 0);
        cyc(1);
        chk("los_evt_1", los_evt_cnt, 1);
        cyc(80);

        for (int i = 0; i < 253; i++) los_pulse(5, 80);
        chk("evt_254", los_evt_cnt, 254);
        los_pulse(5, 80);
        chk("evt_255", los_evt_cnt, 255);
        los_pulse(5, 80);
        chk("evt_sat", los_evt_cnt, 255);

        raw_los = 1'b1;
        cyc(6);
        chk("clr_assert", loss_signal, 1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        raw_los = 1'b0;
        chk("clr_prio", los_evt_cnt, 0);
        cyc(80);
        chk("pre_hold_wa", word_align, 1);

        pma_rstn = 1'b0;
        cyc(1);
        chk("hold_loss", loss_signal, 1);
        chk("hold_cdr", cdr_align, 0);
        chk("hold_wa", word_align, 0);
        cyc(1);
        chk("hold_evt", los_evt_cnt, 1);
        cyc(3);
        pma_rstn = 1'b1;
        cyc(63);
        chk("hold_rel_63", loss_signal, 1);
        cyc(1);
        chk("hold_rel_64", loss_signal, 0);

        cyc(20);
        #2 rst = 1'b1;
        #1;
        chk("arst_loss", loss_signal, 1);
        chk("arst_cdr", cdr_align, 0);
        chk("arst_wa", word_align, 0);
        chk("arst_cnt", los_evt_cnt, 0);
        cyc(2);
        rst = 1'b0;
        cyc(5);
        run = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
